// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data memory arbiter.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package dmem_arb_pkg;

  // Ownership states of the arbiter
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CPU_OWN = 2'd1,
    LDR_OWN = 2'd2
  } state_t;

  // Requester ids, also used to route read returns
  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_LDR = 1'b1;

  // Port B reads the byte just past the addressed word
  localparam int ADDR_OFFSET_B = 4;

endpackage

// File: rtl/dmem_wait_counter.sv
// Saturating loader wait counter; at_max flags that the loader must win next.
// Latency: count updates on the clock edge after inc/clr.
// Backpressure: none; clr has priority over inc.
module dmem_wait_counter
  import dmem_arb_pkg::*;
#(
  parameter int MAX_WAIT = 8,
  parameter int WAIT_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inc,
  input  logic              clr,
  output logic [WAIT_W-1:0] cnt,
  output logic              at_max
);

  assign at_max = (cnt == WAIT_W'(MAX_WAIT));

  // Count loader wait cycles, holding at MAX_WAIT until cleared
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !at_max) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the shared data memory between the CPU MEM stage and the image loader.
// Latency: grant is combinational with the request; read data returns one cycle later.
// Backpressure: the losing requester holds its request; the CPU sees cpu_stall. Optional stats: DMEM_ARB_STATS_EN.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int WORD_W   = 32,
  parameter int BYTE_W   = 8,
  parameter int MAX_WAIT = 8,
  parameter int WAIT_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [BYTE_W-1:0] cpu_wdata,
  input  logic              cpu_lock,
  output logic              cpu_gnt,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [WORD_W-1:0] cpu_rword,
  output logic [BYTE_W-1:0] cpu_rbyte,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [BYTE_W-1:0] ldr_wdata,
  input  logic              ldr_lock,
  output logic              ldr_gnt,
  output logic              ldr_rvalid,
  output logic [WORD_W-1:0] ldr_rword,
  output logic [BYTE_W-1:0] ldr_rbyte,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_a,
  output logic [ADDR_W-1:0] mem_b,
  output logic [BYTE_W-1:0] mem_din,
  input  logic [WORD_W-1:0] mem_do,
  input  logic [BYTE_W-1:0] mem_dob
`ifdef DMEM_ARB_STATS_EN
  ,
  input  logic              stat_clr,
  output logic [31:0]       stat_conflicts,
  output logic [31:0]       stat_starve
`endif
);

  state_t            state;
  state_t            state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              at_max;
  logic              starve;
  logic              win_vld;
  logic              win_id;
  logic              win_lock;
  logic              rd_vld;
  logic              rd_id;

  // Loader has waited long enough that it must beat the CPU, lock or not
  assign starve = ldr_req & at_max;

  dmem_wait_counter #(
    .MAX_WAIT (MAX_WAIT),
    .WAIT_W   (WAIT_W)
  ) u_wait_counter (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc    (ldr_req & ~ldr_gnt),
    .clr    (ldr_gnt | ~ldr_req),
    .cnt    (wait_cnt),
    .at_max (at_max)
  );

  // Ownership state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Pick the winner, drive the memory mux and decide the next owner
  always_comb begin
    win_vld   = 1'b0;
    win_id    = REQ_CPU;
    win_lock  = 1'b0;
    state_nxt = IDLE;
    mem_we    = 1'b0;
    mem_a     = '0;
    mem_din   = '0;
    // A locked loader keeps the port; CPU_OWN grants the same as IDLE
    // because the CPU already wins there unless the guard fires.
    if (!rst_n) begin
      win_vld = 1'b0;
    end else if (state == LDR_OWN && ldr_req) begin
      win_vld = 1'b1;
      win_id  = REQ_LDR;
    end else if (starve) begin
      win_vld = 1'b1;
      win_id  = REQ_LDR;
    end else if (cpu_req) begin
      win_vld = 1'b1;
      win_id  = REQ_CPU;
    end else if (ldr_req) begin
      win_vld = 1'b1;
      win_id  = REQ_LDR;
    end
    if (win_vld) begin
      if (win_id == REQ_LDR) begin
        mem_we   = ldr_we;
        mem_a    = ldr_addr;
        mem_din  = ldr_wdata;
        win_lock = ldr_lock;
      end else begin
        mem_we   = cpu_we;
        mem_a    = cpu_addr;
        mem_din  = cpu_wdata;
        win_lock = cpu_lock;
      end
      if (win_lock) begin
        state_nxt = (win_id == REQ_LDR) ? LDR_OWN : CPU_OWN;
      end
    end
  end

  assign cpu_gnt   = win_vld & (win_id == REQ_CPU);
  assign ldr_gnt   = win_vld & (win_id == REQ_LDR);
  assign cpu_stall = cpu_req & ~cpu_gnt;
  assign mem_b     = mem_a + ADDR_W'(ADDR_OFFSET_B);

  // Remember which requester owns the read issued this cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld <= 1'b0;
      rd_id  <= REQ_CPU;
    end else begin
      rd_vld <= win_vld & ~mem_we;
      rd_id  <= win_id;
    end
  end

  assign cpu_rvalid = rd_vld & (rd_id == REQ_CPU);
  assign ldr_rvalid = rd_vld & (rd_id == REQ_LDR);
  assign cpu_rword  = cpu_rvalid ? mem_do  : '0;
  assign cpu_rbyte  = cpu_rvalid ? mem_dob : '0;
  assign ldr_rword  = ldr_rvalid ? mem_do  : '0;
  assign ldr_rbyte  = ldr_rvalid ? mem_dob : '0;

`ifdef DMEM_ARB_STATS_EN
  // Conflict and forced-grant counters, free-running and wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_conflicts <= '0;
      stat_starve    <= '0;
    end else if (stat_clr) begin
      stat_conflicts <= '0;
      stat_starve    <= '0;
    end else begin
      if (cpu_req && ldr_req) begin
        stat_conflicts <= stat_conflicts + 32'd1;
      end
      if (ldr_gnt && starve && cpu_req) begin
        stat_starve <= stat_starve + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with immediate-assertion checks.
// Latency: inputs driven 1 time unit after posedge, outputs sampled on negedge.
// Backpressure: bench holds requests as a compliant requester would.
module tb_dmem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        cpu_req, cpu_we, cpu_lock;
  logic [31:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_gnt, cpu_stall, cpu_rvalid;
  logic [31:0] cpu_rword;
  logic [7:0]  cpu_rbyte;
  logic        ldr_req, ldr_we, ldr_lock;
  logic [31:0] ldr_addr;
  logic [7:0]  ldr_wdata;
  logic        ldr_gnt, ldr_rvalid;
  logic [31:0] ldr_rword;
  logic [7:0]  ldr_rbyte;
  logic        mem_we;
  logic [31:0] mem_a, mem_b;
  logic [7:0]  mem_din;
  logic [31:0] mem_do;
  logic [7:0]  mem_dob;

  int tests_run;
  int tests_failed;
  int gnt_acc;
  int cpu_acc;

  dmem_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_lock   (cpu_lock),
    .cpu_gnt    (cpu_gnt),
    .cpu_stall  (cpu_stall),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rword  (cpu_rword),
    .cpu_rbyte  (cpu_rbyte),
    .ldr_req    (ldr_req),
    .ldr_we     (ldr_we),
    .ldr_addr   (ldr_addr),
    .ldr_wdata  (ldr_wdata),
    .ldr_lock   (ldr_lock),
    .ldr_gnt    (ldr_gnt),
    .ldr_rvalid (ldr_rvalid),
    .ldr_rword  (ldr_rword),
    .ldr_rbyte  (ldr_rbyte),
    .mem_we     (mem_we),
    .mem_a      (mem_a),
    .mem_b      (mem_b),
    .mem_din    (mem_din),
    .mem_do     (mem_do),
    .mem_dob    (mem_dob)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n     = 1'b0;
    cpu_req   = 1'b0; cpu_we = 1'b0; cpu_lock = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    ldr_req   = 1'b0; ldr_we = 1'b0; ldr_lock = 1'b0; ldr_addr = '0; ldr_wdata = '0;
    mem_do    = '0;
    mem_dob   = '0;

    // Reset state
    smp();
    chk("rst_cpu_gnt", cpu_gnt, 0);
    chk("rst_ldr_gnt", ldr_gnt, 0);
    chk("rst_cpu_rvalid", cpu_rvalid, 0);
    chk("rst_cpu_rword", cpu_rword, 0);
    chk("rst_state", dut.state, 0);
    chk("rst_wait_cnt", dut.wait_cnt, 0);
    tick();
    rst_n = 1'b1;

    // CPU-only read at 0x10
    tick();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
    smp();
    chk("t1_cpu_gnt", cpu_gnt, 1);
    chk("t1_mem_a", mem_a, 32'h10);
    chk("t1_mem_b", mem_b, 32'h14);
    chk("t1_mem_we", mem_we, 0);
    chk("t1_stall", cpu_stall, 0);
    tick();
    cpu_req = 1'b0; mem_do = 32'hDEADBEEF; mem_dob = 8'h5A;
    smp();
    chk("t1_rvalid", cpu_rvalid, 1);
    chk("t1_rword", cpu_rword, 32'hDEADBEEF);
    chk("t1_rbyte", cpu_rbyte, 8'h5A);
    chk("t1_ldr_rvalid", ldr_rvalid, 0);
    chk("t1_stall2", cpu_stall, 0);
    tick();
    smp();
    chk("t1_rvalid_pulse", cpu_rvalid, 0);

    // Starvation guard under a locked CPU
    tick();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h60; cpu_lock = 1'b1;
    ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 32'h200;
    smp();
    chk("t2_c1_cpu_gnt", cpu_gnt, 1);
    chk("t2_c1_ldr_gnt", ldr_gnt, 0);
    chk("t2_c1_wait", dut.wait_cnt, 0);
    tick();
    smp();
    chk("t2_c2_wait", dut.wait_cnt, 1);
    gnt_acc = 0;
    cpu_acc = 1;
    for (int c = 3; c <= 8; c++) begin
      tick();
      smp();
      gnt_acc += int'(ldr_gnt);
      cpu_acc += int'(cpu_gnt);
    end
    cpu_acc += 0;
    chk("t2_wait_at_c8", dut.wait_cnt, 7);
    chk("t2_ldr_gnt_c3_8", gnt_acc, 0);
    chk("t2_cpu_gnt_c3_8", cpu_acc, 7);
    tick();
    smp();
    chk("t2_c9_wait", dut.wait_cnt, 8);
    chk("t2_c9_ldr_gnt", ldr_gnt, 1);
    chk("t2_c9_cpu_gnt", cpu_gnt, 0);
    chk("t2_c9_stall", cpu_stall, 1);
    chk("t2_c9_mem_a", mem_a, 32'h200);
    tick();
    ldr_req = 1'b0; cpu_req = 1'b0; cpu_lock = 1'b0;
    mem_do = 32'hCAFEF00D; mem_dob = 8'h77;
    smp();
    chk("t2_wait_clr", dut.wait_cnt, 0);
    chk("t2_ldr_rvalid", ldr_rvalid, 1);
    chk("t2_ldr_rword", ldr_rword, 32'hCAFEF00D);
    chk("t2_cpu_rvalid", cpu_rvalid, 0);
    chk("t2_state_idle", dut.state, 0);

    // Locked loader write burst with CPU contending
    for (int i = 0; i < 4; i++) begin
      tick();
      ldr_req = 1'b1; ldr_we = 1'b1; ldr_lock = (i < 3);
      ldr_addr = 32'h100 + 32'(i); ldr_wdata = 8'(i + 1);
      cpu_req = (i >= 1); cpu_we = 1'b0; cpu_addr = 32'h30; cpu_lock = 1'b0;
      smp();
      chk("t3_ldr_gnt", ldr_gnt, 1);
      chk("t3_cpu_gnt", cpu_gnt, 0);
      chk("t3_mem_we", mem_we, 1);
      chk("t3_mem_a", mem_a, 32'h100 + 32'(i));
      chk("t3_mem_din", mem_din, 8'(i + 1));
      chk("t3_stall", cpu_stall, (i >= 1) ? 1 : 0);
      if (i == 1) chk("t3_no_wr_rvalid", ldr_rvalid, 0);
    end
    tick();
    ldr_req = 1'b0; ldr_we = 1'b0; ldr_lock = 1'b0;
    smp();
    chk("t3_cpu_gnt_after", cpu_gnt, 1);
    chk("t3_stall_after", cpu_stall, 0);
    chk("t3_wr_no_rvalid", ldr_rvalid, 0);
    tick();
    cpu_req = 1'b0;
    smp();
    chk("t3_cpu_rvalid", cpu_rvalid, 1);

    // Alternating reads CPU then loader
    tick();
    cpu_req = 1'b1; cpu_addr = 32'h20;
    smp();
    chk("t4_cpu_gnt", cpu_gnt, 1);
    tick();
    cpu_req = 1'b0; ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 32'h40;
    mem_do = 32'h11111111; mem_dob = 8'h22;
    smp();
    chk("t4_ldr_gnt", ldr_gnt, 1);
    chk("t4_mem_a", mem_a, 32'h40);
    chk("t4_cpu_rvalid", cpu_rvalid, 1);
    chk("t4_cpu_rword", cpu_rword, 32'h11111111);
    chk("t4_cpu_rbyte", cpu_rbyte, 8'h22);
    chk("t4_ldr_rvalid0", ldr_rvalid, 0);
    tick();
    ldr_req = 1'b0; mem_do = 32'h33333333; mem_dob = 8'h44;
    smp();
    chk("t4_ldr_rvalid", ldr_rvalid, 1);
    chk("t4_ldr_rword", ldr_rword, 32'h33333333);
    chk("t4_ldr_rbyte", ldr_rbyte, 8'h44);
    chk("t4_cpu_rvalid0", cpu_rvalid, 0);

    // Reset right after a CPU read grant
    tick();
    cpu_req = 1'b1; cpu_addr = 32'h50; cpu_lock = 1'b1;
    smp();
    chk("t5_cpu_gnt", cpu_gnt, 1);
    tick();
    cpu_req = 1'b0; cpu_lock = 1'b0; rst_n = 1'b0;
    smp();
    chk("t5_rvalid_drop", cpu_rvalid, 0);
    chk("t5_rword", cpu_rword, 0);
    chk("t5_state", dut.state, 0);
    chk("t5_mem_a", mem_a, 0);
    chk("t5_mem_we", mem_we, 0);
    chk("t5_mem_din", mem_din, 0);
    tick();
    rst_n = 1'b1;
    smp();
    chk("t5_post_cpu_gnt", cpu_gnt, 0);
    chk("t5_post_ldr_gnt", ldr_gnt, 0);
    chk("t5_post_rvalid", cpu_rvalid, 0);

    // Port B address wrap
    tick();
    cpu_req = 1'b1; cpu_addr = 32'hFFFFFFFE;
    smp();
    chk("t6_mem_a", mem_a, 32'hFFFFFFFE);
    chk("t6_mem_b", mem_b, 32'h00000002);
    tick();
    cpu_req = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
